dme_pulse_pair_receiver: RTL and testbench
==========================================

Name: dme_pulse_pair_receiver

Overview:
Parametrised next-generation DME receiver front end. It runs on the single system clock with an internal sample-enable strobe, not a derived clock. It forms a moving-average envelope of the ADC stream, thresholds it, decodes X/Y-mode pulse pairs and reports the range delay, in samples, from start to the first pulse of a valid pair. A timeout is flagged when no valid pair arrives in time. It sits between the ADC capture logic and the range computation / host register logic.

Parameters:
CLK_DIV, 100, clk cycles per sample strobe (100 MHz -> 1 MHz); must be >= 2
ADC_W, 12, ADC sample and envelope width
AVG_LOG2, 7, moving-average window = 2**AVG_LOG2 samples
SPACING_X, 12, X-mode pulse-pair spacing in samples
SPACING_Y, 36, Y-mode pulse-pair spacing in samples
SPACING_TOL, 1, allowed spacing deviation, +/- samples
TIMEOUT, 4095, maximum elapsed samples before abort
CNT_W, 32, width of elapsed counter and p1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  level-sampled request; honoured only in IDLE
mode  in  1  0 = X (SPACING_X), 1 = Y (SPACING_Y); latched on accepted start
threshold  in  ADC_W  envelope detection threshold
adc_signal  in  ADC_W  unsigned ADC sample
busy  out  1  high in ARMED or PAIR
p1  out  CNT_W  elapsed-sample count at the first pulse of the last valid pair
valid  out  1  one-clk pulse when p1 updates
timeout  out  1  one-clk pulse on abort
env  out  ADC_W  current envelope, for debug

Behaviour:
- The clock and reset are as stated: one clock, `clk`; reset is synchronous and active-high, on port `reset`.
- Reset values: all outputs 0, state IDLE, divider 0, window contents 0, sum 0, edge history 0.
- Divider: counts 0..CLK_DIV-1. `se` (sample enable) is high for one clk when count == CLK_DIV-1. All datapath and FSM updates happen only on `se`, except that start is accepted and valid/timeout are cleared on any clk.
- Moving average: on `se`, the shift window receives adc_signal.
  - sum <= sum + adc_signal - oldest, where sum is ADC_W+AVG_LOG2 bits wide and cannot overflow.
  - env = sum >> AVG_LOG2, registered.
  - The window contents are not cleared by start.
- Edge detect: above = (env >= threshold), registered on `se`. An edge event is above & ~above_d, evaluated on `se`.
- Elapsed counter: cleared when start is accepted. It increments on every `se` while in ARMED or PAIR and saturates at 2**CNT_W-1.
- Pair spacing S = mode_lat ? SPACING_Y : SPACING_X. Let d = elapsed - t1.
- FSM:
  - IDLE: start=1 -> ARMED, latch mode, clear elapsed. The accepting cycle is not an `se` action.
  - ARMED: edge -> t1 <= elapsed, go to PAIR.
  - PAIR, edge with S-TOL <= d <= S+TOL: p1 <= t1, valid pulses on the next clk, go to IDLE.
  - PAIR, edge outside that window: restart the pair with t1 <= elapsed, stay in PAIR.
  - PAIR, no edge and d > S+TOL: go back to ARMED.
  - ARMED or PAIR with elapsed == TIMEOUT on `se` and no valid pair on that `se`: timeout pulses, go to IDLE.
- Simultaneous valid pair and timeout on the same `se`: valid wins and timeout is not asserted.
- start while busy is ignored. start held high re-arms immediately after returning to IDLE.
- p1 holds its value across failed or timed-out measurements and changes only with valid.
- Reset mid-measurement returns to IDLE on the next clk with no valid or timeout pulse.
- Latency: the edge is detected on the `se` after env crosses threshold; valid rises one clk after the accepting `se`.

Decomposition:
- Package dme_pkg holds:
  - state enum (IDLE, ARMED, PAIR)
  - MODE_X/MODE_Y constants
  - the default spacing and timeout localparams
- One natural sub-module: dme_moving_average.
  - Parameters ADC_W and AVG_LOG2; ports clk, reset, en, in, out.
  - It replaces the current free-running averager and runs on the sample enable.
- The divider, edge detect and FSM stay in the top.

Test Plan:
(Use CLK_DIV=4, AVG_LOG2=2 and threshold=100 for speed in all scenarios.)
- Reset: hold reset for 3 clk mid-stream -> p1=0, valid=0, timeout=0, busy=0, env=0. The first `se` occurs exactly 4 clk after reset release.
- X pair: start, mode=0. Drive step adc=400 at sample 20 for 4 samples, then 0, then a second identical burst at sample 32 -> valid pulses once, p1=21 (20 plus 1-sample envelope lag), busy drops.
- Y pair, tolerance boundaries: mode=1 with second burst spacing 37 -> accepted. Repeat with spacing 38 -> no valid; the spurious edge becomes the new t1.
- Wrong spacing then good pair: bursts at 10, 15, 27 in X mode -> p1 reflects first pulse 15 (+lag); the edge at 10 is discarded.
- Timeout: start with adc=0 constantly, TIMEOUT=50 -> timeout pulses at elapsed 50, valid=0, p1 unchanged. Also check start pulsed during busy is ignored.
- Moving average arithmetic: feed adc=4095 continuously -> env=4095 after 4 samples with no overflow. Then feed 0 -> env decays 4095, 3071, 2047, 1023, 0.

Source files
------------

// File: rtl/dme_pkg.sv
// Shared types and defaults for the DME pulse-pair receiver.
package dme_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, PAIR} state_e;

  localparam logic MODE_X = 1'b0;
  localparam logic MODE_Y = 1'b1;

  localparam int DEF_SPACING_X   = 12;
  localparam int DEF_SPACING_Y   = 36;
  localparam int DEF_SPACING_TOL = 1;
  localparam int DEF_TIMEOUT     = 4095;
endpackage

// File: rtl/dme_moving_average.sv
// Boxcar moving average over 2**AVG_LOG2 samples, advanced only on en.
module dme_moving_average #(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [ADC_W-1:0] in,
  output logic [ADC_W-1:0] out
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = ADC_W + AVG_LOG2;

  logic [DEPTH-1:0][ADC_W-1:0] win_q;
  logic [SUM_W-1:0]            sum_q, sum_d;
  logic [ADC_W-1:0]            out_q;

  // Modular add/sub: any transient wrap cancels since the true window sum fits SUM_W.
  assign sum_d = sum_q + SUM_W'(in) - SUM_W'(win_q[DEPTH-1]);
  assign out   = out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q <= '0;
      sum_q <= '0;
      out_q <= '0;
    end else if (en) begin
      win_q <= {win_q[DEPTH-2:0], in};
      sum_q <= sum_d;
      out_q <= sum_d[SUM_W-1:AVG_LOG2];
    end
  end
endmodule

// File: rtl/dme_pulse_pair_receiver.sv
// DME receiver front end: envelope, threshold edge detect and X/Y pulse-pair
// decoding, reporting the range delay in samples to the first pulse.
module dme_pulse_pair_receiver import dme_pkg::*; #(
  parameter int CLK_DIV     = 100,
  parameter int ADC_W       = 12,
  parameter int AVG_LOG2    = 7,
  parameter int SPACING_X   = DEF_SPACING_X,
  parameter int SPACING_Y   = DEF_SPACING_Y,
  parameter int SPACING_TOL = DEF_SPACING_TOL,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [ADC_W-1:0] threshold,
  input  logic [ADC_W-1:0] adc_signal,
  output logic             busy,
  output logic [CNT_W-1:0] p1,
  output logic             valid,
  output logic             timeout,
  output logic [ADC_W-1:0] env
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LO_X = CNT_W'(SPACING_X - SPACING_TOL);
  localparam logic [CNT_W-1:0] HI_X = CNT_W'(SPACING_X + SPACING_TOL);
  localparam logic [CNT_W-1:0] LO_Y = CNT_W'(SPACING_Y - SPACING_TOL);
  localparam logic [CNT_W-1:0] HI_Y = CNT_W'(SPACING_Y + SPACING_TOL);
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic             se, hit, edge_ev, above_q, mode_q;
  logic [CNT_W-1:0] elapsed_q, elapsed_inc, t1_q, p1_q, d, s_lo, s_hi;
  logic             valid_q, timeout_q;
  logic             in_win, tmo_hit;

  dme_moving_average #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_avg (
    .clk   (clk),
    .reset (reset),
    .en    (se),
    .in    (adc_signal),
    .out   (env)
  );

  assign se          = (div_q == DIV_W'(CLK_DIV - 1));
  assign hit         = (env >= threshold);
  assign edge_ev     = hit & ~above_q;
  assign elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + CNT_W'(1);
  assign d           = elapsed_q - t1_q;
  assign s_lo        = (mode_q == MODE_Y) ? LO_Y : LO_X;
  assign s_hi        = (mode_q == MODE_Y) ? HI_Y : HI_X;
  assign in_win      = (d >= s_lo) && (d <= s_hi);
  assign tmo_hit     = (elapsed_q == TMO);

  assign busy    = (state_q != IDLE);
  assign p1      = p1_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      above_q <= 1'b0;
    end else begin
      div_q <= se ? '0 : div_q + DIV_W'(1);
      if (se) above_q <= hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= MODE_X;
      elapsed_q <= '0;
      t1_q      <= '0;
      p1_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          state_q   <= ARMED;
          mode_q    <= mode;
          elapsed_q <= '0;
        end
        ARMED: if (se) begin
          elapsed_q <= elapsed_inc;
          if (tmo_hit) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else if (edge_ev) begin
            t1_q    <= elapsed_q;
            state_q <= PAIR;
          end
        end
        PAIR: if (se) begin
          elapsed_q <= elapsed_inc;
          // A good pair on the timeout sample still counts as a measurement.
          if (edge_ev && in_win) begin
            p1_q    <= t1_q;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else if (edge_ev) begin
            t1_q <= elapsed_q;
          end else if (d > s_hi) begin
            state_q <= ARMED;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dme_pulse_pair_receiver.sv
// Directed scoreboard bench: stimulus pushes expected pair/timeout events,
// a negedge monitor pops and compares them when the DUT reports one.
module tb_dme_pulse_pair_receiver;
  localparam int ADC_W = 12;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset, start, mode;
  logic [ADC_W-1:0] threshold, adc_signal, env;
  logic             busy, valid, timeout;
  logic [CNT_W-1:0] p1;

  typedef struct {
    bit is_to;
    int samp;
    int p1;
  } exp_t;

  exp_t q[$];
  int   vec = 0;
  int   bad = 0;
  int   last_se = -1;

  dme_pulse_pair_receiver #(
    .CLK_DIV(4), .ADC_W(ADC_W), .AVG_LOG2(2), .SPACING_X(12), .SPACING_Y(36),
    .SPACING_TOL(1), .TIMEOUT(50), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .threshold  (threshold),
    .adc_signal (adc_signal),
    .busy       (busy),
    .p1         (p1),
    .valid      (valid),
    .timeout    (timeout),
    .env        (env)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint expv);
    vec++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic next_se();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Entered just after a sample-strobe edge; sample n is the n-th strobe after start.
  task automatic run_meas(input bit md, input int n_samp, input int b0, input int b1,
                          input int b2, input int blen, input int kind,
                          input int ev_samp, input int ev_p1, input int busy_start_at);
    exp_t e;
    if (kind != 0) begin
      e.is_to = (kind == 2);
      e.samp  = ev_samp;
      e.p1    = ev_p1;
      q.push_back(e);
    end
    mode = md;
    start = 1'b1;
    adc_signal = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    last_se = 0;
    chk("busy_armed", busy, 1);
    for (int n = 1; n < n_samp; n++) begin
      adc_signal = ((n >= b0 && n < b0 + blen) || (n >= b1 && n < b1 + blen) ||
                    (n >= b2 && n < b2 + blen)) ? ADC_W'(400) : '0;
      start = (n == busy_start_at);
      next_se();
      last_se = n;
    end
    start = 1'b0;
    adc_signal = '0;
    if (kind != 0) chk("busy_end", busy, 0);
    chk("sb_drained", q.size(), 0);
    q.delete();
  endtask

  always @(negedge clk) begin
    if (valid || timeout) begin
      vec++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: valid=%0d timeout=%0d at sample %0d, none expected",
                 valid, timeout, last_se);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (valid == e.is_to || timeout != e.is_to || last_se != e.samp ||
            p1 != CNT_W'(e.p1)) begin
          bad++;
          $display("FAIL event: got valid=%0d timeout=%0d sample=%0d p1=%0d, expected timeout=%0d sample=%0d p1=%0d",
                   valid, timeout, last_se, p1, e.is_to, e.samp, e.p1);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    threshold = ADC_W'(100); adc_signal = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p1", p1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_env", env, 0);
    reset = 1'b0;
    next_se();

    // X pair, 4-sample bursts at 20 and 32: edges at 21 and 33.
    run_meas(1'b0, 40, 20, 32, -100, 4, 1, 33, 21, -1);
    // X at -TOL: edges 6 and 17 (d=11).
    run_meas(1'b0, 24, 5, 16, -100, 1, 1, 17, 6, -1);
    // Wrong spacing then good pair: edge 11 discarded, 16 and 28 pair.
    run_meas(1'b0, 36, 10, 15, 27, 1, 1, 28, 16, -1);
    // Stale first pulse falls back to ARMED, then +TOL pair (d=13).
    run_meas(1'b0, 42, 2, 20, 33, 1, 1, 34, 21, -1);
    // Y pair at +TOL: edges 3 and 40 (d=37).
    run_meas(1'b1, 48, 2, 39, -100, 4, 1, 40, 3, -1);
    // Y at 38: restarts pair at 41, then times out at 50, p1 held.
    run_meas(1'b1, 56, 2, 40, -100, 4, 2, 50, 3, -1);
    // Quiet input with a start pulse while busy: still times out at 50.
    run_meas(1'b0, 56, -100, -100, -100, 1, 2, 50, 3, 20);

    // Reset mid-measurement with the input already at full scale.
    run_meas(1'b0, 10, -100, -100, -100, 1, 0, 0, 0, -1);
    adc_signal = ADC_W'(4095);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_p1", p1, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_env", env, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("env_before_first_se", env, 0);
    @(posedge clk); #1;
    chk("env_first_se", env, 1023);
    next_se(); chk("env_rise2", env, 2047);
    next_se(); chk("env_rise3", env, 3071);
    next_se(); chk("env_full", env, 4095);
    next_se(); chk("env_hold", env, 4095);
    adc_signal = '0;
    next_se(); chk("env_decay1", env, 3071);
    next_se(); chk("env_decay2", env, 2047);
    next_se(); chk("env_decay3", env, 1023);
    next_se(); chk("env_decay4", env, 0);
    chk("busy_after_avg", busy, 0);
    chk("sb_final", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
